// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
// Widths are expressed at 64 bits and truncated by the users to XLEN.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [63:0] DEFAULT_RESET_VEC  = 64'h0000_0000_8000_0000;
  localparam int          DEFAULT_ALIGN_BITS = 2;
  localparam logic [63:0] STEP               = 64'd1 << DEFAULT_ALIGN_BITS;

  function automatic logic [63:0] step_size(input int align_bits);
    return 64'd1 << align_bits;
  endfunction

  // Ones in every bit above the instruction alignment boundary.
  function automatic logic [63:0] align_mask(input int align_bits);
    return ~((64'd1 << align_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap, aligned redirect, misaligned
// redirect (rejected), sequential advance, hold.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int ALIGN_BITS = DEFAULT_ALIGN_BITS
) (
  input  logic [XLEN-1:0] cur_pc_i,
  input  logic            fetch_valid_i,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            redirect_taken_o,
  output logic            misalign_hit_o
);

  localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(ALIGN_BITS));
  localparam logic [XLEN-1:0] INC  = XLEN'(step_size(ALIGN_BITS));

  always_comb begin
    next_pc_o        = cur_pc_i;
    redirect_taken_o = 1'b0;
    misalign_hit_o   = 1'b0;
    if (trap_valid_i) begin
      next_pc_o        = trap_pc_i & MASK;
      redirect_taken_o = 1'b1;
    end else if (redirect_valid_i) begin
      if ((redirect_pc_i & ~MASK) == '0) begin
        next_pc_o        = redirect_pc_i;
        redirect_taken_o = 1'b1;
      end else begin
        misalign_hit_o = 1'b1;
      end
    end else if (fetch_valid_i && fetch_ready_i && !stall_i) begin
      next_pc_o = cur_pc_i + INC;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: reset vector, fetch handshake, redirect
// and trap steering, epoch tracking and a sticky halt.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | held in reset or just released; PC sits at the reset vector
// ST_RUN  | issuing fetches, accepting redirects/traps/halt
// ST_HALT | frozen until reset; fetch_valid_o low, halted_o high
module pc_gen
  import pc_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter logic [63:0] RESET_VEC  = DEFAULT_RESET_VEC,
  parameter int          ALIGN_BITS = DEFAULT_ALIGN_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            epoch_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            halt_i,
  output logic            halted_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VEC);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            epoch_q, epoch_d;
  logic            halted_q, halted_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic [XLEN-1:0] sel_pc;
  logic            sel_taken;
  logic            sel_misalign;

  pc_next_sel #(
    .XLEN      (XLEN),
    .ALIGN_BITS(ALIGN_BITS)
  ) u_next_sel (
    .cur_pc_i        (pc_q),
    .fetch_valid_i   (valid_q),
    .fetch_ready_i   (fetch_ready_i),
    .stall_i         (stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .trap_valid_i    (trap_valid_i),
    .trap_pc_i       (trap_pc_i),
    .next_pc_o       (sel_pc),
    .redirect_taken_o(sel_taken),
    .misalign_hit_o  (sel_misalign)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    valid_d         = valid_q;
    epoch_d         = epoch_q;
    halted_d        = halted_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      ST_RUN: begin
        // Halt outranks any redirect arriving in the same cycle.
        if (halt_i) begin
          state_d  = ST_HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else begin
          pc_d    = sel_pc;
          epoch_d = epoch_q ^ sel_taken;
          if (sel_misalign) begin
            misalign_d      = 1'b1;
            misalign_addr_d = redirect_pc_i;
          end
        end
      end
      ST_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_PC;
      valid_q         <= 1'b0;
      epoch_q         <= 1'b0;
      halted_q        <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      valid_q         <= valid_d;
      epoch_q         <= epoch_d;
      halted_q        <= halted_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign fetch_valid_o   = valid_q;
  assign fetch_pc_o      = pc_q;
  assign epoch_o         = epoch_q;
  assign halted_o        = halted_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 64-bit and a 32-bit instance share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ready;
  logic        redir_v;
  logic [63:0] redir_pc;
  logic        trap_v;
  logic [63:0] trap_pc;
  logic        halt;

  logic [31:0] redir_pc32;
  logic [31:0] trap_pc32;
  assign redir_pc32 = redir_pc[31:0];
  assign trap_pc32  = trap_pc[31:0];

  logic        d64_valid, d64_epoch, d64_halted, d64_mis;
  logic [63:0] d64_pc, d64_maddr;
  logic        d32_valid, d32_epoch, d32_halted, d32_mis;
  logic [31:0] d32_pc, d32_maddr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
    .fetch_valid_o(d64_valid), .fetch_pc_o(d64_pc), .epoch_o(d64_epoch),
    .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
    .trap_valid_i(trap_v), .trap_pc_i(trap_pc), .halt_i(halt),
    .halted_o(d64_halted), .misalign_o(d64_mis), .misalign_addr_o(d64_maddr)
  );

  pc_gen #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
    .fetch_valid_o(d32_valid), .fetch_pc_o(d32_pc), .epoch_o(d32_epoch),
    .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc32),
    .trap_valid_i(trap_v), .trap_pc_i(trap_pc32), .halt_i(halt),
    .halted_o(d32_halted), .misalign_o(d32_mis), .misalign_addr_o(d32_maddr)
  );

  typedef struct {
    logic [63:0] pc;
    logic        valid;
    logic        epoch;
    logic        halted;
    logic        mis;
    logic [63:0] maddr;
    logic        started;
  } model_t;

  model_t m64, m32;
  logic   rst_seen;

  // Behavioural view: what the fetch front end must look like after one edge.
  function automatic model_t step(input model_t m, input logic [63:0] mask,
                                  input logic r, input logic st, input logic rdy,
                                  input logic rv, input logic [63:0] rpc,
                                  input logic tv, input logic [63:0] tpc,
                                  input logic h);
    model_t n = m;
    logic [63:0] rp = rpc & mask;
    logic [63:0] tp = tpc & mask;
    n.mis = 1'b0;
    if (r) begin
      n.pc = 64'h8000_0000 & mask;
      n.valid = 0; n.epoch = 0; n.halted = 0; n.maddr = 0; n.started = 0;
    end else if (!m.started) begin
      n.started = 1; n.valid = 1;
    end else if (m.halted) begin
      // frozen
    end else if (h) begin
      n.halted = 1; n.valid = 0;
    end else if (tv) begin
      n.pc = tp - (tp % 4);
      n.epoch = !m.epoch;
    end else if (rv) begin
      if (rp % 4 == 0) begin
        n.pc = rp;
        n.epoch = !m.epoch;
      end else begin
        n.mis = 1; n.maddr = rp;
      end
    end else if (rdy && !st) begin
      n.pc = (m.pc + 64'd4) & mask;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      m64 = step(m64, 64'hFFFF_FFFF_FFFF_FFFF, rst, stall, ready, redir_v, redir_pc,
                 trap_v, trap_pc, halt);
      m32 = step(m32, 64'h0000_0000_FFFF_FFFF, rst, stall, ready, redir_v, redir_pc,
                 trap_v, trap_pc, halt);
      rst_seen = rst;
      #1;
      chk("pc64", d64_pc, m64.pc);
      chk("valid64", {63'd0, d64_valid}, {63'd0, m64.valid});
      chk("epoch64", {63'd0, d64_epoch}, {63'd0, m64.epoch});
      chk("halted64", {63'd0, d64_halted}, {63'd0, m64.halted});
      chk("mis64", {63'd0, d64_mis}, {63'd0, m64.mis});
      if (m64.mis || rst_seen) chk("maddr64", d64_maddr, m64.maddr);
      chk("pc32", {32'd0, d32_pc}, m32.pc);
      chk("valid32", {63'd0, d32_valid}, {63'd0, m32.valid});
      chk("epoch32", {63'd0, d32_epoch}, {63'd0, m32.epoch});
      chk("halted32", {63'd0, d32_halted}, {63'd0, m32.halted});
      chk("mis32", {63'd0, d32_mis}, {63'd0, m32.mis});
      if (m32.mis || rst_seen) chk("maddr32", {32'd0, d32_maddr}, m32.maddr);
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit_pc(input string name, input logic [63:0] exp64, input logic [31:0] exp32);
    chk({name, "_dut64"}, d64_pc, exp64);
    chk({name, "_model64"}, m64.pc, exp64);
    chk({name, "_dut32"}, {32'd0, d32_pc}, {32'd0, exp32});
  endtask

  initial begin
    rst = 1; stall = 0; ready = 1; redir_v = 0; redir_pc = 0;
    trap_v = 0; trap_pc = 0; halt = 0;
    cyc(3);
    lit_pc("reset_pc", 64'h8000_0000, 32'h8000_0000);
    chk("reset_valid", {63'd0, d64_valid}, 64'd0);

    rst = 0;
    cyc(); lit_pc("first_fetch", 64'h8000_0000, 32'h8000_0000);
    chk("first_valid", {63'd0, d64_valid}, 64'd1);
    cyc(); lit_pc("seq1", 64'h8000_0004, 32'h8000_0004);
    cyc(); lit_pc("seq2", 64'h8000_0008, 32'h8000_0008);
    cyc(2); lit_pc("seq4", 64'h8000_0010, 32'h8000_0010);

    ready = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); lit_pc("notready_hold", 64'h8000_0010, 32'h8000_0010);
    end
    ready = 1;
    cyc(); lit_pc("ready_adv", 64'h8000_0014, 32'h8000_0014);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); lit_pc("stall_hold", 64'h8000_0014, 32'h8000_0014);
    end
    stall = 0;
    cyc(); lit_pc("stall_release", 64'h8000_0018, 32'h8000_0018);

    stall = 1; redir_v = 1; redir_pc = 64'h8000_1000;
    cyc(); lit_pc("redir_stall", 64'h8000_1000, 32'h8000_1000);
    chk("redir_epoch", {63'd0, d64_epoch}, 64'd1);
    stall = 0; redir_v = 0;

    trap_v = 1; trap_pc = 64'h8000_0103; redir_v = 1; redir_pc = 64'h8000_2002;
    cyc(); lit_pc("trap_wins", 64'h8000_0100, 32'h8000_0100);
    chk("trap_epoch", {63'd0, d64_epoch}, 64'd0);
    chk("trap_no_mis", {63'd0, d64_mis}, 64'd0);
    trap_v = 0;

    redir_pc = 64'h8000_0020;
    cyc(); lit_pc("redir_20", 64'h8000_0020, 32'h8000_0020);
    redir_pc = 64'h8000_2002;
    cyc(); lit_pc("misalign_hold", 64'h8000_0020, 32'h8000_0020);
    chk("misalign_pulse", {63'd0, d64_mis}, 64'd1);
    chk("misalign_addr", d64_maddr, 64'h8000_2002);
    chk("misalign_epoch", {63'd0, d64_epoch}, 64'd1);
    redir_pc = 64'h8000_0001;
    cyc(); chk("misalign_b2b", {63'd0, d32_mis}, 64'd1);
    chk("misalign_addr_b2b", {32'd0, d32_maddr}, 64'h8000_0001);
    redir_v = 0;
    cyc(); lit_pc("after_misalign", 64'h8000_0024, 32'h8000_0024);
    chk("misalign_done", {63'd0, d64_mis}, 64'd0);

    redir_v = 1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(); lit_pc("top_addr", 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC);
    redir_v = 0;
    cyc(); lit_pc("wrap", 64'h0, 32'h0);

    halt = 1; trap_v = 1; trap_pc = 64'h1000;
    cyc(); lit_pc("halt_wins", 64'h0, 32'h0);
    chk("halted", {63'd0, d32_halted}, 64'd1);
    chk("halt_valid", {63'd0, d32_valid}, 64'd0);
    halt = 0; trap_v = 0; redir_v = 1; redir_pc = 64'h2000;
    cyc(2); lit_pc("halt_ignores_redir", 64'h0, 32'h0);
    redir_pc = 64'h2002;
    cyc(); chk("halt_no_mis", {63'd0, d64_mis}, 64'd0);
    redir_v = 0;

    rst = 1;
    cyc(); lit_pc("rst_from_halt", 64'h8000_0000, 32'h8000_0000);
    chk("rst_unhalt", {63'd0, d64_halted}, 64'd0);
    rst = 0;
    cyc(); lit_pc("restart", 64'h8000_0000, 32'h8000_0000);
    cyc(); lit_pc("restart_seq", 64'h8000_0004, 32'h8000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
